// File: rtl/spi_pwm_host.sv
// SPI master for the 7-channel PWM slave: one 2-byte command/data
// transaction per accepted request. Byte 0 = {write, 4'b0, addr}, byte 1 =
// write data (or 0x00 on a read while the PWM level returns on miso).
// sclk is generated from clk with HALF_PERIOD clk cycles per half-period.
`timescale 1ns/1ps

module spi_pwm_host #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       write,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CNT_W = $clog2(HALF_PERIOD + 1);
  localparam int unsigned BIT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  // Bits 14..0 of the shift word; bit 15 goes straight to mosi at acceptance.
  logic [14:0]      tx;
  logic [7:0]       rx;
  logic             is_wr;
  logic             last_c;

  // Last clk cycle of the current sclk phase.
  assign last_c = (cnt == CNT_LAST);

  // Transaction sequencer with registered SPI pins and handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      is_wr   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      sclk    <= 1'b0;
      cs      <= 1'b1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE) begin
        cnt <= last_c ? '0 : cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            tx      <= {4'b0000, addr, (write ? wdata : 8'h00)};
            is_wr   <= write;
            mosi    <= write;
            cs      <= 1'b0;
            sclk    <= 1'b0;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (last_c) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (last_c) begin
            // Data byte arrives LSB first during the second byte.
            if (bit_cnt >= BIT_W'(8)) begin
              rx <= {miso, rx[7:1]};
            end
            sclk  <= 1'b0;
            mosi  <= tx[14];
            tx    <= {tx[13:0], 1'b0};
            state <= LOW;
          end
        end
        LOW: begin
          if (last_c) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(15)) begin
              cs    <= 1'b1;
              mosi  <= 1'b0;
              done  <= 1'b1;
              if (!is_wr) begin
                rdata <= rx;
              end
              state <= GAP;
            end else begin
              sclk  <= 1'b1;
              state <= HIGH;
            end
          end
        end
        GAP: begin
          if (last_c) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_pwm_host.sv
// Bench for spi_pwm_host: two instances (HALF_PERIOD 4 and 1), each with a
// behavioural PWM slave; a scoreboard queue per instance checked on done.
`timescale 1ns/1ps

module tb_spi_pwm_host;

  typedef struct {
    logic [7:0]  rdata;
    logic [15:0] word;
    int unsigned done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int unsigned cyc = 0;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  // Cycle counter used for absolute timing expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: HALF_PERIOD = 4
  logic       a_start, a_write, a_busy, a_done, a_sclk, a_cs, a_mosi, a_miso;
  logic [2:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  // Instance B: HALF_PERIOD = 1
  logic       b_start, b_write, b_busy, b_done, b_sclk, b_cs, b_mosi, b_miso;
  logic [2:0] b_addr;
  logic [7:0] b_wdata, b_rdata;

  spi_pwm_host #(.HALF_PERIOD(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .write(a_write), .addr(a_addr),
    .wdata(a_wdata), .busy(a_busy), .done(a_done), .rdata(a_rdata),
    .sclk(a_sclk), .cs(a_cs), .mosi(a_mosi), .miso(a_miso)
  );

  spi_pwm_host #(.HALF_PERIOD(1)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .write(b_write), .addr(b_addr),
    .wdata(b_wdata), .busy(b_busy), .done(b_done), .rdata(b_rdata),
    .sclk(b_sclk), .cs(b_cs), .mosi(b_mosi), .miso(b_miso)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t mk(input logic [7:0] rd, input logic [15:0] w, input int unsigned dc);
    exp_t e;
    e.rdata = rd;
    e.word = w;
    e.done_cyc = dc;
    return e;
  endfunction

  // ---------------- slave model A ----------------
  logic [15:0] a_sh = '0, a_word = '0;
  logic [7:0]  a_cmd = '0;
  logic [4:0]  a_ecnt = '0, a_edges = '0;
  logic [7:0]  a_regs [8] = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h44, 8'h55, 8'h66, 8'h00};

  // Shift mosi on sclk rise; restart the edge count when cs falls.
  always @(posedge a_sclk or negedge a_cs) begin
    if (!a_sclk) a_ecnt <= '0;
    else if (!a_cs) begin
      a_sh   <= {a_sh[14:0], a_mosi};
      a_ecnt <= a_ecnt + 5'd1;
      if (a_ecnt == 5'd7) a_cmd <= {a_sh[6:0], a_mosi};
    end
  end

  // Record the frame and commit a complete write when cs rises.
  always @(posedge a_cs) begin
    a_word  <= a_sh;
    a_edges <= a_ecnt;
    if (a_ecnt == 5'd16 && a_sh[15]) a_regs[a_sh[10:8]] <= a_sh[7:0];
  end

  assign a_miso = (!a_cs && a_ecnt >= 5'd9) ? a_regs[a_cmd[2:0]][3'(a_ecnt - 5'd9)] : 1'b0;

  // ---------------- slave model B ----------------
  logic [15:0] b_sh = '0, b_word = '0;
  logic [7:0]  b_cmd = '0;
  logic [4:0]  b_ecnt = '0, b_edges = '0;
  logic [7:0]  b_regs [8] = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'h9A, 8'h00};

  always @(posedge b_sclk or negedge b_cs) begin
    if (!b_sclk) b_ecnt <= '0;
    else if (!b_cs) begin
      b_sh   <= {b_sh[14:0], b_mosi};
      b_ecnt <= b_ecnt + 5'd1;
      if (b_ecnt == 5'd7) b_cmd <= {b_sh[6:0], b_mosi};
    end
  end

  always @(posedge b_cs) begin
    b_word  <= b_sh;
    b_edges <= b_ecnt;
    if (b_ecnt == 5'd16 && b_sh[15]) b_regs[b_sh[10:8]] <= b_sh[7:0];
  end

  assign b_miso = (!b_cs && b_ecnt >= 5'd9) ? b_regs[b_cmd[2:0]][3'(b_ecnt - 5'd9)] : 1'b0;

  // ---------------- scoreboards ----------------
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Monitor A: every done pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (a_done) begin
      check("a_done_expected", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("a_rdata", a_rdata, ea.rdata);
        check("a_mosi_word", a_word, ea.word);
        check("a_sclk_edges", a_edges, 16);
        check("a_done_cycle", cyc, ea.done_cyc);
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (b_done) begin
      check("b_done_expected", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("b_rdata", b_rdata, eb.rdata);
        check("b_mosi_word", b_word, eb.word);
        check("b_sclk_edges", b_edges, 16);
        check("b_done_cycle", cyc, eb.done_cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic go_a(input logic w, input logic [2:0] ad, input logic [7:0] wd,
                      output int unsigned acc);
    @(negedge clk);
    a_start = 1'b1; a_write = w; a_addr = ad; a_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    a_start = 1'b0;
  endtask

  task automatic go_b(input logic w, input logic [2:0] ad, input logic [7:0] wd,
                      output int unsigned acc);
    @(negedge clk);
    b_start = 1'b1; b_write = w; b_addr = ad; b_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    b_start = 1'b0;
  endtask

  initial begin
    int unsigned acc;
    int unsigned t0;
    reset = 1'b0;
    a_start = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_start = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs", a_cs, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rdata", a_rdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Read channel 3 -> 0xA5
    go_a(1'b0, 3'd3, 8'h00, acc);
    qa.push_back(mk(8'hA5, 16'h0300, acc + 132));
    check("rd_cs_fall", a_cs, 0);
    check("rd_busy_on", a_busy, 1);
    wait_until(acc + 131);
    check("rd_cs_low_last", a_cs, 0);
    wait_until(acc + 132);
    check("rd_cs_rise", a_cs, 1);
    wait_until(acc + 135);
    check("rd_busy_gap", a_busy, 1);
    wait_until(acc + 136);
    check("rd_busy_off", a_busy, 0);

    // Write channel 6 = 0x7F; rdata keeps 0xA5
    go_a(1'b1, 3'd6, 8'h7F, acc);
    qa.push_back(mk(8'hA5, 16'h867F, acc + 132));
    wait_until(acc + 136);
    check("wr_slave_ch6", a_regs[6], 8'h7F);
    check("wr_busy_off", a_busy, 0);

    // start pulses while busy are ignored
    go_a(1'b1, 3'd2, 8'h3C, acc);
    qa.push_back(mk(8'hA5, 16'h823C, acc + 132));
    wait_until(acc + 9);
    a_start = 1'b1; a_write = 1'b0; a_addr = 3'd5; a_wdata = 8'hC3;
    @(negedge clk);
    a_start = 1'b0;
    wait_until(acc + 99);
    a_start = 1'b1; a_write = 1'b0; a_addr = 3'd1; a_wdata = 8'h99;
    @(negedge clk);
    a_start = 1'b0;
    wait_until(acc + 136);
    check("ign_slave_ch2", a_regs[2], 8'h3C);
    check("ign_busy_off", a_busy, 0);
    repeat (4) @(negedge clk);
    check("ign_still_idle", a_busy, 0);

    // Reset mid-read at cycle 40, then a full read
    go_a(1'b0, 3'd3, 8'h00, acc);
    wait_until(acc + 39);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_cs", a_cs, 1);
    check("mid_rst_sclk", a_sclk, 0);
    check("mid_rst_mosi", a_mosi, 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_rdata", a_rdata, 0);
    reset = 1'b1;
    @(negedge clk);
    go_a(1'b0, 3'd3, 8'h00, acc);
    qa.push_back(mk(8'hA5, 16'h0300, acc + 132));
    wait_until(acc + 136);

    // HALF_PERIOD=1: read channel 5 -> 0xFF, one-clk sclk phases
    go_b(1'b0, 3'd5, 8'h00, acc);
    qb.push_back(mk(8'hFF, 16'h0500, acc + 33));
    for (int m = 0; m <= 32; m++) begin
      wait_until(acc + m);
      check($sformatf("hp1_sclk_%0d", m), b_sclk, m % 2);
    end
    wait_until(acc + 34);
    check("hp1_busy_off", b_busy, 0);

    // HALF_PERIOD=1 back-to-back reads with start held high
    @(negedge clk);
    b_start = 1'b1; b_write = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    b_addr = 3'd7;
    qb.push_back(mk(8'h00, 16'h0000, acc + 33));
    qb.push_back(mk(8'h00, 16'h0700, acc + 35 + 33));
    wait_until(acc + 33);
    check("b2b_gap_cs", b_cs, 1);
    wait_until(acc + 34);
    check("b2b_idle_cs", b_cs, 1);
    check("b2b_idle_busy", b_busy, 0);
    wait_until(acc + 35);
    check("b2b_second_cs", b_cs, 0);
    check("b2b_second_busy", b_busy, 1);
    b_start = 1'b0;
    wait_until(acc + 35 + 34);
    check("b2b_busy_off", b_busy, 0);

    // Drain scoreboards with a bounded wait
    t0 = cyc;
    while ((qa.size() + qb.size()) > 0 && cyc < t0 + 300) @(negedge clk);
    check("queues_drained", qa.size() + qb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
